// File: rtl/sdp_ram_pipe.sv
// -----------------------------------------------------------------------------
// sdp_ram_pipe
//
// Simple-dual-port RAM on a single clock: one write port and one read port.
// It is the common buffer memory under FIFOs, line buffers and packet stores.
// The storage is inferred from arrays, so no vendor macro is instantiated.
// The memory is split into one array per byte lane. This makes each per-byte
// write enable a plain write to its own array.
//
// Parameters:
//   DATA_W     data width, a multiple of 8 (8..72)
//   DEPTH      number of words (2..65536); need not be a power of two
//   DO_REG     0: read latency 1; 1: extra output register gated by REGCE
//   WRITE_MODE same-address read-during-write: 0 returns the old word,
//              1 returns the old word merged with the enabled new bytes
//   INIT_VAL   power-up contents of every word (reset does not touch memory)
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset of the read pipeline only
//   WREN/WE    write enable and byte enables (WE[i] covers DI[8i+7:8i])
//   WRADDR/DI  write address and data; out-of-range writes are dropped
//   RDEN       read enable; RDADDR is the read address (out of range reads 0)
//   REGCE      output register clock enable (used only when DO_REG=1)
//   DO         read data
//   DO_VALID   one-cycle pulse for each read result on DO
//   COLLISION  pulse aligned with DO_VALID: the read hit the address written
//              in the same cycle
//
// Optional feature, enabled by defining SDP_RAM_PIPE_PARITY_EN:
//   Each byte stores one extra even-parity bit.
//   PINJ (input) inverts the stored parity of a write, for fault-injection tests.
//   PERR (output) pulses with DO_VALID when any byte of the read word fails
//   its parity check.
// -----------------------------------------------------------------------------
module sdp_ram_pipe #(
   parameter int                DATA_W     = 32,
   parameter int                DEPTH      = 1024,
   parameter int                DO_REG     = 0,
   parameter int                WRITE_MODE = 0,
   parameter logic [DATA_W-1:0] INIT_VAL   = '0,
   localparam int               ADDR_W     = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int               NB         = DATA_W / 8
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              WREN,
   input  logic [NB-1:0]     WE,
   input  logic [ADDR_W-1:0] WRADDR,
   input  logic [DATA_W-1:0] DI,
   input  logic              RDEN,
   input  logic              REGCE,
   input  logic [ADDR_W-1:0] RDADDR,
`ifdef SDP_RAM_PIPE_PARITY_EN
   input  logic              PINJ,
   output logic              PERR,
`endif
   output logic [DATA_W-1:0] DO,
   output logic              DO_VALID,
   output logic              COLLISION
);

`ifdef SDP_RAM_PIPE_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   // Stored lane width: one data byte plus an optional parity bit.
   localparam int LW = 8 + PB;

   // DEPTH widened by one bit, so that the range checks also work when DEPTH
   // is a power of two.
   localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

   logic              wr_in_range;
   logic              rd_in_range;
   logic              collision_next;
   logic [DATA_W-1:0] s1_data;
   logic              s1_valid_reg;
   logic              s1_col_reg;
`ifdef SDP_RAM_PIPE_PARITY_EN
   logic [NB-1:0]     s1_err;
   logic              s1_perr;
`endif

   assign wr_in_range    = {1'b0, WRADDR} < DEPTH_A;
   assign rd_in_range    = {1'b0, RDADDR} < DEPTH_A;
   // A write with no byte enabled is not a write, so it cannot collide.
   assign collision_next = RDEN & WREN & (|WE) & wr_in_range & (RDADDR == WRADDR);

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_lane
         localparam logic [7:0] INIT_B = INIT_VAL[8*gi +: 8];
`ifdef SDP_RAM_PIPE_PARITY_EN
         localparam logic [LW-1:0] INIT_W = {^INIT_B, INIT_B};
`else
         localparam logic [LW-1:0] INIT_W = INIT_B;
`endif
         logic [LW-1:0] mem [DEPTH] = '{default: INIT_W};
         logic [LW-1:0] wr_word;
         logic [LW-1:0] rd_reg;
         logic          lane_wr;

`ifdef SDP_RAM_PIPE_PARITY_EN
         assign wr_word = {(^DI[8*gi +: 8]) ^ PINJ, DI[8*gi +: 8]};
`else
         assign wr_word = DI[8*gi +: 8];
`endif
         assign lane_wr = WREN & WE[gi] & wr_in_range;

         always_ff @(posedge CLK) begin
            if (lane_wr) begin
               mem[WRADDR] <= wr_word;
            end
         end

         // Stage-1 data register. An ordinary memory read returns the
         // pre-write word. In write-first mode, an enabled byte of a
         // colliding write is forwarded directly from the write data.
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               rd_reg <= '0;
            end else if (RDEN) begin
               if (!rd_in_range) begin
                  rd_reg <= '0;
               end else if ((WRITE_MODE == 1) && collision_next && WE[gi]) begin
                  rd_reg <= wr_word;
               end else begin
                  rd_reg <= mem[RDADDR];
               end
            end
         end

         assign s1_data[8*gi +: 8] = rd_reg[7:0];
`ifdef SDP_RAM_PIPE_PARITY_EN
         // The lane fails its check when the data bits and the stored
         // parity bit together have odd parity.
         assign s1_err[gi] = ^rd_reg;
`endif
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_valid_reg <= 1'b0;
         s1_col_reg   <= 1'b0;
      end else begin
         s1_valid_reg <= RDEN;
         s1_col_reg   <= collision_next;
      end
   end

`ifdef SDP_RAM_PIPE_PARITY_EN
   assign s1_perr = s1_valid_reg & (|s1_err);
`endif

   generate
      if (DO_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] s2_data_reg;
         logic              s2_valid_reg;
         logic              s2_col_reg;
`ifdef SDP_RAM_PIPE_PARITY_EN
         logic              s2_perr_reg;
`endif

         // If REGCE is low, this register holds its data and drops its flags.
         // A stage-1 result that is not captured at that point is lost.
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               s2_data_reg  <= '0;
               s2_valid_reg <= 1'b0;
               s2_col_reg   <= 1'b0;
`ifdef SDP_RAM_PIPE_PARITY_EN
               s2_perr_reg  <= 1'b0;
`endif
            end else if (REGCE) begin
               s2_data_reg  <= s1_data;
               s2_valid_reg <= s1_valid_reg;
               s2_col_reg   <= s1_col_reg;
`ifdef SDP_RAM_PIPE_PARITY_EN
               s2_perr_reg  <= s1_perr;
`endif
            end else begin
               s2_valid_reg <= 1'b0;
               s2_col_reg   <= 1'b0;
`ifdef SDP_RAM_PIPE_PARITY_EN
               s2_perr_reg  <= 1'b0;
`endif
            end
         end

         assign DO        = s2_data_reg;
         assign DO_VALID  = s2_valid_reg;
         assign COLLISION = s2_col_reg;
`ifdef SDP_RAM_PIPE_PARITY_EN
         assign PERR      = s2_perr_reg;
`endif
      end else begin : g_noreg
         // REGCE has no effect without the output register.
         logic unused_regce;
         assign unused_regce = REGCE;

         assign DO        = s1_data;
         assign DO_VALID  = s1_valid_reg;
         assign COLLISION = s1_col_reg;
`ifdef SDP_RAM_PIPE_PARITY_EN
         assign PERR      = s1_perr;
`endif
      end
   endgenerate

endmodule

// File: tb/tb_sdp_ram_pipe.sv
// -----------------------------------------------------------------------------
// Testbench for sdp_ram_pipe. Two configurations receive the same stimulus:
//   dut0: DO_REG=0, WRITE_MODE=0 (read-first, latency 1)
//   dut1: DO_REG=1, WRITE_MODE=1 (write-first, output register with REGCE)
// Both use DEPTH=1000, so addresses 1000..1023 are out of range.
// The stimulus task keeps a word-level model of the memory. For each read it
// computes the expected result and the cycle in which that result is due, and
// pushes both into a queue for each DUT. The monitor pops an entry whenever a
// DUT raises DO_VALID. In cycles with no result, the monitor checks that DO
// holds its expected value.
// -----------------------------------------------------------------------------
module tb_sdp_ram_pipe;
   localparam int DEP = 1000;
   localparam int HN  = 64;
`ifdef SDP_RAM_PIPE_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   typedef struct {
      int unsigned due;
      logic [31:0] data;
      logic        col;
      logic        perr;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wren, rden, regce;
   logic [3:0]  we;
   logic [9:0]  wraddr, rdaddr;
   logic [31:0] di;
`ifdef SDP_RAM_PIPE_PARITY_EN
   logic        pinj;
`endif
   logic [31:0] dout  [2];
   logic        dv    [2];
   logic        dcol  [2];
   logic        dperr [2];

   // Reference model state
   logic [31:0] mem_m [DEP];
   logic [3:0]  flg_m [DEP];        // bytes whose stored parity was inverted
   exp_t        q [2][$];
   logic [31:0] hold_val [2][HN];
   int unsigned hold_cyc [2][HN];
   logic [31:0] s1_a, s1_b, b_do;
   logic        pend_v;
   exp_t        pend;
   exp_t        mx;

   int unsigned cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sdp_ram_pipe #(.DATA_W(32), .DEPTH(DEP), .DO_REG(0), .WRITE_MODE(0)) u_dut0 (
      .CLK(clk), .RST_N(rst_n), .WREN(wren), .WE(we), .WRADDR(wraddr), .DI(di),
      .RDEN(rden), .REGCE(regce), .RDADDR(rdaddr),
`ifdef SDP_RAM_PIPE_PARITY_EN
      .PINJ(pinj), .PERR(dperr[0]),
`endif
      .DO(dout[0]), .DO_VALID(dv[0]), .COLLISION(dcol[0])
   );

   sdp_ram_pipe #(.DATA_W(32), .DEPTH(DEP), .DO_REG(1), .WRITE_MODE(1)) u_dut1 (
      .CLK(clk), .RST_N(rst_n), .WREN(wren), .WE(we), .WRADDR(wraddr), .DI(di),
      .RDEN(rden), .REGCE(regce), .RDADDR(rdaddr),
`ifdef SDP_RAM_PIPE_PARITY_EN
      .PINJ(pinj), .PERR(dperr[1]),
`endif
      .DO(dout[1]), .DO_VALID(dv[1]), .COLLISION(dcol[1])
   );

`ifndef SDP_RAM_PIPE_PARITY_EN
   assign dperr[0] = 1'b0;
   assign dperr[1] = 1'b0;
`endif

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            q[d].delete();
            n_cmp++;
            if (dout[d] !== 32'h0 || dv[d] !== 1'b0 || dcol[d] !== 1'b0 || dperr[d] !== 1'b0) begin
               n_bad++;
               $display("FAIL reset_clear dut%0d cyc=%0d: got do=%h valid=%b col=%b perr=%b, want all 0",
                        d, cyc, dout[d], dv[d], dcol[d], dperr[d]);
            end
         end else if (dv[d] === 1'b1) begin
            n_cmp++;
            if (q[d].size() == 0) begin
               n_bad++;
               $display("FAIL spurious_valid dut%0d cyc=%0d: got valid=1 do=%h, want no result",
                        d, cyc, dout[d]);
            end else begin
               mx = q[d].pop_front();
               if (mx.due != cyc || dout[d] !== mx.data || dcol[d] !== mx.col || dperr[d] !== mx.perr) begin
                  n_bad++;
                  $display("FAIL read_beat dut%0d: got cyc=%0d do=%h col=%b perr=%b, want cyc=%0d do=%h col=%b perr=%b",
                           d, cyc, dout[d], dcol[d], dperr[d], mx.due, mx.data, mx.col, mx.perr);
               end else begin
                  $display("ok read dut%0d cyc=%0d do=%h col=%b perr=%b", d, cyc, dout[d], dcol[d], dperr[d]);
               end
            end
         end else begin
            if (q[d].size() != 0 && q[d][0].due <= cyc) begin
               n_cmp++;
               n_bad++;
               $display("FAIL missing_valid dut%0d cyc=%0d: got valid=%b, want do=%h due at cyc=%0d",
                        d, cyc, dv[d], q[d][0].data, q[d][0].due);
               void'(q[d].pop_front());
            end
            if (hold_cyc[d][cyc % HN] == cyc) begin
               n_cmp++;
               if (dout[d] !== hold_val[d][cyc % HN] || dcol[d] !== 1'b0 || dperr[d] !== 1'b0) begin
                  n_bad++;
                  $display("FAIL idle_hold dut%0d cyc=%0d: got do=%h col=%b perr=%b, want do=%h col=0 perr=0",
                           d, cyc, dout[d], dcol[d], dperr[d], hold_val[d][cyc % HN]);
               end
            end
         end
      end
   end

   // Applies one cycle of stimulus and records the expected results.
   // Memory rules: reads return the contents from before this cycle's write,
   // with a write-first merge for dut1 on a collision.
   // dut1 rule: a read appears on the following edge only if REGCE is high
   // on that edge; otherwise the read is lost.
   task automatic drive(input logic wr, input logic [3:0] wbe, input logic [9:0] wa,
                        input logic [31:0] wd, input logic rd, input logic [9:0] ra,
                        input logic ce, input logic inj);
      int unsigned e;
      logic        c, inj_e;
      logic [31:0] old_d, new_d;
      logic [3:0]  old_f, new_f;
      exp_t        x;
      @(negedge clk);
      #1;
      e     = cyc + 1;
      inj_e = PAR & inj;
      if (ce) begin
         b_do = s1_b;
         if (pend_v) begin
            pend.due = e;
            q[1].push_back(pend);
         end
      end
      pend_v = 1'b0;
      c = rd && wr && (wbe != 4'h0) && (ra == wa) && (wa < DEP);
      if (rd) begin
         old_d = (ra < DEP) ? mem_m[ra] : 32'h0;
         old_f = (ra < DEP) ? flg_m[ra] : 4'h0;
         new_d = old_d;
         new_f = old_f;
         if (c) begin
            for (int i = 0; i < 4; i++) begin
               if (wbe[i]) begin
                  new_d[8*i +: 8] = wd[8*i +: 8];
                  new_f[i]        = inj_e;
               end
            end
         end
         x.due  = e;
         x.data = old_d;
         x.col  = c;
         x.perr = |old_f;
         q[0].push_back(x);
         s1_a = old_d;
         pend.due  = 0;
         pend.data = new_d;
         pend.col  = c;
         pend.perr = |new_f;
         pend_v    = 1'b1;
         s1_b      = new_d;
      end
      hold_val[0][e % HN] = s1_a;
      hold_cyc[0][e % HN] = e;
      hold_val[1][e % HN] = b_do;
      hold_cyc[1][e % HN] = e;
      wren = wr; we = wbe; wraddr = wa; di = wd;
      rden = rd; rdaddr = ra; regce = ce;
`ifdef SDP_RAM_PIPE_PARITY_EN
      pinj = inj_e;
`endif
      if (wr && wa < DEP) begin
         for (int i = 0; i < 4; i++) begin
            if (wbe[i]) begin
               mem_m[wa][8*i +: 8] = wd[8*i +: 8];
               flg_m[wa][i]        = inj_e;
            end
         end
      end
   endtask

   task automatic idle(input logic ce);
      drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0, ce, 1'b0);
   endtask

   task automatic rd_at(input logic [9:0] ra);
      drive(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, ra, 1'b1, 1'b0);
   endtask

   task automatic wr_at(input logic [9:0] wa, input logic [3:0] wbe, input logic [31:0] wd,
                        input logic inj);
      drive(1'b1, wbe, wa, wd, 1'b0, 10'd0, 1'b1, inj);
   endtask

   // Asserts reset just after an active edge, so that the next falling-edge
   // sample sees it before any further clock edge.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      wren = 1'b0; rden = 1'b0; we = 4'h0; regce = 1'b1;
      pend_v = 1'b0; s1_a = 32'h0; s1_b = 32'h0; b_do = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      wren = 1'b0; rden = 1'b0; regce = 1'b1; we = 4'h0;
      wraddr = 10'd0; rdaddr = 10'd0; di = 32'h0;
`ifdef SDP_RAM_PIPE_PARITY_EN
      pinj = 1'b0;
`endif
      for (int i = 0; i < DEP; i++) begin
         mem_m[i] = 32'h0;
         flg_m[i] = 4'h0;
      end
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < HN; i++) begin
            hold_cyc[d][i] = 32'hFFFF_FFFF;
            hold_val[d][i] = 32'h0;
         end
      end
      s1_a = 32'h0; s1_b = 32'h0; b_do = 32'h0; pend_v = 1'b0;
      pend = '{0, 32'h0, 1'b0, 1'b0};
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;

      // Basic write, then a read on the next cycle
      wr_at(10'd5, 4'hF, 32'hDEADBEEF, 1'b0);
      rd_at(10'd5);
      // Byte enables
      wr_at(10'd3, 4'hF, 32'h11223344, 1'b0);
      wr_at(10'd3, 4'b0101, 32'hAABBCCDD, 1'b0);
      rd_at(10'd3);
      // Same-address read and write in one cycle
      wr_at(10'd7, 4'hF, 32'h0, 1'b0);
      drive(1'b1, 4'hF, 10'd7, 32'hFFFFFFFF, 1'b1, 10'd7, 1'b1, 1'b0);
      rd_at(10'd7);
      // Back-to-back reads, then REGCE low for one cycle
      rd_at(10'd5); rd_at(10'd3); rd_at(10'd7); rd_at(10'd5);
      idle(1'b1); idle(1'b0); idle(1'b1);
      // Out-of-range write and read
      wr_at(10'd1000, 4'hF, 32'h0000005A, 1'b0);
      rd_at(10'd1000);
      rd_at(10'd0);
      // Reset while reads are in flight
      rd_at(10'd5); rd_at(10'd3);
      do_reset();
      idle(1'b1); idle(1'b1);
      rd_at(10'd5);
      idle(1'b1);
      // Parity injection (with the feature disabled, the model holds injection at 0)
      wr_at(10'd9, 4'hF, 32'h12345678, 1'b1);
      rd_at(10'd9);
      wr_at(10'd10, 4'hF, 32'h9ABCDEF0, 1'b0);
      rd_at(10'd10);
      idle(1'b1);

      // Random traffic concentrated on a small address window, so that
      // collisions occur. Some writes and reads go out of range.
      for (int n = 0; n < 1500; n++) begin : rnd
         logic [9:0] wa, ra;
         int         sel;
         sel = $urandom_range(0, 9);
         if (sel == 0)      wa = 10'(1000 + $urandom_range(0, 23));
         else if (sel == 1) wa = 10'($urandom_range(0, 999));
         else               wa = 10'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) ra = wa;
         else if ($urandom_range(0, 9) == 0) ra = 10'($urandom_range(0, 1023));
         else ra = 10'($urandom_range(0, 15));
         drive(1'($urandom_range(0, 1)), 4'($urandom), wa, $urandom,
               1'($urandom_range(0, 9) < 6), ra, 1'($urandom_range(0, 9) < 8),
               1'($urandom_range(0, 1)));
      end

      repeat (6) idle(1'b1);
      @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
